// File: rtl/avalon_pio_pkg.sv
// Shared register addresses and configuration enumerations for the PIO peripheral.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    typedef enum logic [1:0] {
        PIO_OUT   = 2'd0,
        PIO_IN    = 2'd1,
        PIO_BIDIR = 2'd2
    } pio_mode_e;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_ANY  = 2'd3
    } edge_type_e;

    typedef enum logic [1:0] {
        IRQ_NONE  = 2'd0,
        IRQ_LEVEL = 2'd1,
        IRQ_EDGE  = 2'd2
    } irq_type_e;

endpackage

// File: rtl/avalon_pio_gen2_edge_detect.sv
// Input synchroniser chain plus a one-cycle-delayed copy for rise/fall detection.
module pio_edge_detect #(
    parameter int WIDTH       = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            prev <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign rise    = sync_in & ~prev;
    assign fall    = ~sync_in & prev;

endmodule

// File: rtl/avalon_pio_gen2.sv
// Parametrised Avalon-MM PIO: output/input/bidirectional port with edge capture and interrupt.
module avalon_pio_gen2
    import avalon_pio_pkg::*;
#(
    parameter int          WIDTH       = 7,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          MODE        = 0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          IRQ_TYPE    = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam pio_mode_e  MODE_E = pio_mode_e'(MODE[1:0]);
    localparam edge_type_e EDGE_E = edge_type_e'(EDGE_TYPE[1:0]);
    localparam irq_type_e  IRQ_E  = irq_type_e'(IRQ_TYPE[1:0]);
    localparam logic [WIDTH-1:0] DIR_RESET = (MODE_E == PIO_OUT) ? '1 : '0;

    // Slave handshake: zero wait states. A write is accepted on any clock edge
    // where chipselect=1 and write_n=0; readdata is valid combinationally
    // from address in the same cycle, no waitrequest.
    logic             wr;
    logic [WIDTH-1:0] wd;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    logic [WIDTH-1:0] data_out, direction, irqmask, edgecapture;
    logic [WIDTH-1:0] sync_in, rise, fall;
    logic [WIDTH-1:0] edge_sel, cap_en, ec_clr, rd_val;
    logic             irq_src;

    pio_edge_detect #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .sync_in (sync_in),
        .rise    (rise),
        .fall    (fall)
    );

    always_comb begin
        edge_sel = '0;
        case (EDGE_E)
            EDGE_RISE: edge_sel = rise;
            EDGE_FALL: edge_sel = fall;
            EDGE_ANY:  edge_sel = rise | fall;
            default:   edge_sel = '0;
        endcase
    end

    // Pins driven as outputs in bidirectional mode must not capture their own toggles.
    assign cap_en = (MODE_E == PIO_BIDIR) ? ~direction : '1;
    assign ec_clr = (wr && address == ADDR_EDGE) ? wd : '0;

    always_comb begin
        irq_src = 1'b0;
        case (IRQ_E)
            IRQ_LEVEL: irq_src = |(sync_in & irqmask);
            IRQ_EDGE:  irq_src = |(edgecapture & irqmask);
            default:   irq_src = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out    <= RESET_VALUE[WIDTH-1:0];
            direction   <= DIR_RESET;
            irqmask     <= '0;
            edgecapture <= '0;
            irq         <= 1'b0;
        end else begin
            if (wr && MODE_E != PIO_IN) begin
                case (address)
                    ADDR_DATA:   data_out <= wd;
                    ADDR_OUTSET: data_out <= data_out | wd;
                    ADDR_OUTCLR: data_out <= data_out & ~wd;
                    default:     data_out <= data_out;
                endcase
            end
            if (wr && address == ADDR_DIR && MODE_E == PIO_BIDIR) direction <= wd;
            if (wr && address == ADDR_IRQMASK && IRQ_E != IRQ_NONE) irqmask <= wd;
            // A new edge in the same cycle as its clear keeps the bit set.
            if (EDGE_E != EDGE_NONE)
                edgecapture <= (edgecapture & ~ec_clr) | (edge_sel & cap_en);
            irq <= irq_src;
        end
    end

    always_comb begin
        rd_val = '0;
        case (address)
            ADDR_DATA: begin
                case (MODE_E)
                    PIO_IN:    rd_val = sync_in;
                    PIO_BIDIR: rd_val = (direction & data_out) | (~direction & sync_in);
                    default:   rd_val = data_out;
                endcase
            end
            ADDR_DIR:     rd_val = direction;
            ADDR_IRQMASK: rd_val = irqmask;
            ADDR_EDGE:    rd_val = edgecapture;
            default:      rd_val = '0;
        endcase
    end

    assign readdata = 32'(rd_val);
    assign out_port = data_out;
    assign oe       = direction;

endmodule

// File: doc/avalon_pio_gen2.md
Name: avalon_pio_gen2

Overview:
- Parametrised general-purpose I/O peripheral on the Avalon-MM system bus; next generation of the fixed-width output-only PIO.
- Adds:
  - configurable width;
  - input, output or bidirectional mode;
  - input synchronisation;
  - edge capture;
  - interrupt mask and interrupt request.
- Sits beside the CPU in the system interconnect, driving LEDs/7-segment lines and sampling switches/buttons.

Parameters:
- WIDTH, 7, port width in bits; legal 1..32.
- RESET_VALUE, 0, out_port value after reset (WIDTH bits).
- MODE, 0, 0 = output only, 1 = input only, 2 = bidirectional.
- EDGE_TYPE, 0, 0 = no capture, 1 = rising, 2 = falling, 3 = any edge.
- IRQ_TYPE, 0, 0 = none, 1 = level, 2 = edge.
- SYNC_STAGES, 2, input synchroniser depth; legal 2..3.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word register index.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- readdata  out  32  read data; zero-extended above WIDTH.
- in_port  in  WIDTH  external inputs, asynchronous to clk.
- out_port  out  WIDTH  output data register.
- oe  out  WIDTH  per-bit output enable (direction).
- irq  out  1  interrupt request, active high.

Behaviour:
- Clock and reset: one clock domain. reset_n is asynchronous assert, active-low; deassertion must be synchronous to clk at system level.
- Reset values:
  - data_out = RESET_VALUE;
  - direction = 0 in MODE 2, all-ones in MODE 0, 0 in MODE 1;
  - irqmask = 0; edgecapture = 0; synchroniser and previous-sample flops = 0;
  - irq = 0.
- Write strobe = chipselect & ~write_n. Read is combinational, zero wait states: readdata = mux(address).
- Register map:
  - 0 data. Write: data_out <= writedata[WIDTH-1:0] (ignored in MODE 1). Read: synchronised input in MODE 1; data_out in MODE 0; MODE 2 per bit: direction ? data_out : sync_in.
  - 1 direction. R/W only in MODE 2; otherwise write ignored and reads the fixed value.
  - 2 irqmask. R/W when IRQ_TYPE != 0, else reads 0.
  - 3 edgecapture. Read returns capture bits. Write-1-to-clear per bit. Reads 0 when EDGE_TYPE = 0.
  - 4 outset: data_out <= data_out | wd.
  - 5 outclear: data_out <= data_out & ~wd.
  - 6, 7: read 0, writes ignored.
- Outputs: out_port = data_out; oe = direction.
- Input path:
  - in_port passes through SYNC_STAGES flops to give sync_in; prev <= sync_in every cycle.
  - Edge terms per bit: rise = sync_in & ~prev; fall = ~sync_in & prev; any = rise | fall.
  - Latency: in_port change -> sync_in visible at address 0 after SYNC_STAGES cycles; edgecapture sets one cycle later.
- Edge capture: bit i sets on the selected edge. Same-cycle edge and write-1-to-clear: set wins, the edge is not lost. Bits whose direction = 1 in MODE 2 never capture.
- irq: registered, one cycle after its source changes.
  - IRQ_TYPE 1: irq = |(sync_in & irqmask).
  - IRQ_TYPE 2: irq = |(edgecapture & irqmask).
  - irq deasserts the cycle after the last masked source clears.
- Boundaries:
  - WIDTH = 32 means no zero padding.
  - A glitch shorter than one clk period may be missed; this is acceptable.
  - Reset mid-operation clears all state immediately, including pending captures.
  - Writes with chipselect = 0 have no effect.

Decomposition:
- Package avalon_pio_pkg:
  - address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGE=3, ADDR_OUTSET=4, ADDR_OUTCLR=5;
  - MODE, EDGE_TYPE and IRQ_TYPE enumerations.
- One sub-module, pio_edge_detect: WIDTH-wide synchroniser plus edge detector producing sync_in and edge pulse vectors. Register file and capture logic stay in the top.

Test Plan:
- Reset with WIDTH=7, RESET_VALUE=7'h55 -> out_port=7'h55, oe=7'h7F, irq=0, address 2 and 3 read 0.
- Write 0x12 to addr 0, then 0x41 to addr 4, then 0x02 to addr 5 -> out_port 0x12, then 0x53, then 0x51; readback matches each cycle after the write.
- MODE 1, EDGE_TYPE 1, IRQ_TYPE 2, mask=0x01; drive in_port bit0 0->1 -> edgecapture=0x01 at cycle SYNC_STAGES+1, irq=1 one cycle later. Write 0x01 to addr 3 -> irq=0 next cycle.
- Rising edge on bit0 in the same cycle as a clear write of 0x01 -> edgecapture bit0 remains 1.
- MODE 2: direction=0x0F, data=0x3C, in_port=0x70 -> out_port=0x3C, oe=0x0F, addr 0 reads 0x7C.
- Assert reset_n low mid-sequence with edgecapture=0x05 and irq=1 -> all registers and irq go to reset values without waiting for a clock edge.
